// File: rtl/ay_psg_core.sv
// AY-3-8910-class sound generator: latched-address register file, tone/noise generators, mixer, amplitude sum.
// Optional envelope generator is enabled by defining AY_PSG_ENVELOPE_EN.
module ay_psg_core #(
  parameter int NUM_CHANNELS = 3,
  parameter int TONE_BITS    = 12,
  parameter int NOISE_BITS   = 5,
  parameter int PRESCALE     = 16,
  parameter int OUTPUT_BITS  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    addr_we,
  input  logic                    data_we,
  input  logic [7:0]              bus_data,
  output logic [7:0]              rd_data,
  output logic [NUM_CHANNELS-1:0] chan_out,
  output logic [OUTPUT_BITS-1:0]  audio_out
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [7:0] TONE_HI_MASK = 8'((1 << (TONE_BITS - 8)) - 1);
  localparam logic [7:0] NOISE_MASK   = 8'((1 << NOISE_BITS) - 1);

  logic [7:0]    regs [16];
  logic [3:0]    addr;
  logic [PW-1:0] pre_cnt;
  logic          tick;

  function automatic logic [7:0] reg_mask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5:  reg_mask = TONE_HI_MASK;
      4'd6:              reg_mask = NOISE_MASK;
      4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
      4'd13:             reg_mask = 8'h0F;
      default:           reg_mask = 8'hFF;
    endcase
  endfunction

  // Data write uses the address latched before this edge, so a same-cycle addr_we applies afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) regs[k] <= (k == 7) ? 8'h3F : 8'h00;
      addr    <= 4'd0;
      rd_data <= 8'h00;
    end else begin
      if (data_we) regs[addr] <= bus_data & reg_mask(addr);
      if (addr_we) addr <= bus_data[3:0];
      rd_data <= regs[addr];
    end
  end

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) pre_cnt <= '0;
    else               pre_cnt <= pre_cnt + 1'b1;
  end

  // Noise generator: same wrap rule as the tone counters, LFSR steps on each wrap.
  logic [NOISE_BITS-1:0] noise_cnt;
  logic [NOISE_BITS-1:0] noise_per;
  logic [NOISE_BITS-1:0] noise_lim;
  logic [16:0]           lfsr;
  logic                  noise;

  assign noise_per = regs[6][NOISE_BITS-1:0];
  assign noise_lim = (noise_per == '0) ? '0 : noise_per - 1'b1;
  assign noise     = lfsr[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      noise_cnt <= '0;
      lfsr      <= 17'h00001;
    end else if (tick) begin
      if (noise_cnt >= noise_lim) begin
        noise_cnt <= '0;
        lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        noise_cnt <= noise_cnt + 1'b1;
      end
    end
  end

`ifdef AY_PSG_ENVELOPE_EN
  logic [15:0] env_per;
  logic [15:0] env_lim;
  logic [15:0] env_cnt;
  logic [3:0]  env_lvl;
  logic        env_att;
  logic        env_hold;
  logic [3:0]  shape;

  assign env_per = {regs[12], regs[11]};
  assign env_lim = (env_per == 16'd0) ? 16'd0 : env_per - 16'd1;
  assign shape   = regs[13][3:0];

  // Reset behaves like a restart with shape 0; a write to R13 restarts from the new shape.
  always_ff @(posedge clk) begin
    if (reset) begin
      env_cnt  <= 16'd0;
      env_lvl  <= 4'hF;
      env_att  <= 1'b0;
      env_hold <= 1'b0;
    end else if (data_we && addr == 4'd13) begin
      env_cnt  <= 16'd0;
      env_att  <= bus_data[2];
      env_lvl  <= bus_data[2] ? 4'h0 : 4'hF;
      env_hold <= 1'b0;
    end else if (tick) begin
      if (env_cnt >= env_lim) begin
        env_cnt <= 16'd0;
        if (!env_hold) begin
          if (env_lvl == (env_att ? 4'hF : 4'h0)) begin
            if (!shape[3]) begin
              env_lvl  <= 4'h0;
              env_hold <= 1'b1;
            end else if (shape[0]) begin
              env_lvl  <= shape[1] ? ~env_lvl : env_lvl;
              env_hold <= 1'b1;
            end else if (shape[1]) begin
              env_att <= ~env_att;
            end else begin
              env_lvl <= env_att ? 4'h0 : 4'hF;
            end
          end else begin
            env_lvl <= env_att ? env_lvl + 4'd1 : env_lvl - 4'd1;
          end
        end
      end else begin
        env_cnt <= env_cnt + 16'd1;
      end
    end
  end
`endif

  logic [NUM_CHANNELS-1:0] tone;
  logic [NUM_CHANNELS-1:0] chan_on;
  logic [3:0]              level [NUM_CHANNELS];
  logic [5:0]              psum  [NUM_CHANNELS+1];

  assign psum[0] = 6'd0;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    logic [TONE_BITS-1:0] per;
    logic [TONE_BITS-1:0] lim;
    logic [TONE_BITS-1:0] cnt;
    logic                 tone_q;

    assign per = {regs[2*i+1][TONE_BITS-9:0], regs[2*i]};
    assign lim = (per == '0) ? '0 : per - 1'b1;

    // >= rather than == so a period shrunk below the current count wraps on the next tick.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt    <= '0;
        tone_q <= 1'b0;
      end else if (tick) begin
        if (cnt >= lim) begin
          cnt    <= '0;
          tone_q <= ~tone_q;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign tone[i]    = tone_q;
    assign chan_on[i] = (tone_q | regs[7][i]) & (noise | regs[7][3+i]);

`ifdef AY_PSG_ENVELOPE_EN
    assign level[i] = !chan_out[i] ? 4'd0 : (regs[8+i][4] ? env_lvl : regs[8+i][3:0]);
`else
    assign level[i] = chan_out[i] ? regs[8+i][3:0] : 4'd0;
`endif
    assign psum[i+1] = psum[i] + {2'b00, level[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chan_out  <= '0;
      audio_out <= '0;
    end else begin
      chan_out  <= chan_on;
      audio_out <= OUTPUT_BITS'(psum[NUM_CHANNELS]) << (OUTPUT_BITS - 6);
    end
  end

endmodule

// File: tb/tb_ay_psg_core.sv
// Directed bench for ay_psg_core with PRESCALE=2 (one generator tick every two clocks).
module tb_ay_psg_core;
  logic       clk = 1'b0;
  logic       reset;
  logic       addr_we;
  logic       data_we;
  logic [7:0] bus_data;
  logic [7:0] rd_data;
  logic [2:0] chan_out;
  logic [7:0] audio_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ay_psg_core #(
    .NUM_CHANNELS(3), .TONE_BITS(12), .NOISE_BITS(5), .PRESCALE(2), .OUTPUT_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .addr_we(addr_we), .data_we(data_we),
    .bus_data(bus_data), .rd_data(rd_data), .chan_out(chan_out), .audio_out(audio_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    addr_we = 1'b1; bus_data = {4'h0, a};
    cyc();
    addr_we = 1'b0; data_we = 1'b1; bus_data = d;
    cyc();
    data_we = 1'b0; bus_data = 8'h00;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
    addr_we = 1'b1; bus_data = {4'h0, a};
    cyc();
    addr_we = 1'b0; bus_data = 8'h00;
    cyc();
    d = rd_data;
  endtask

  task automatic wait_toggle(input int budget, output int n);
    logic p;
    p = chan_out[0];
    n = 0;
    while (chan_out[0] === p && n < budget) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    int          n, bad, hi, nz;
    logic        prev;
    logic [16:0] m;
    bit          mseq [400];
    bit          obs  [80];
    bit          found;

    addr_we = 1'b0; data_we = 1'b0; bus_data = 8'h00; reset = 1'b1;
    cyc(); cyc();
    check("reset_rd_data", rd_data, 8'h00);
    check("reset_chan_out", chan_out, 3'b000);
    check("reset_audio", audio_out, 8'h00);
    reset = 1'b0;

    read_reg(4'd7, d); check("reset_r7", d, 8'h3F);
    read_reg(4'd0, d); check("reset_r0", d, 8'h00);
    nz = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (audio_out !== 8'h00) nz++;
    end
    check("muted_audio_nonzero_cycles", nz, 0);

    write_reg(4'd1, 8'hFF);  read_reg(4'd1, d);  check("mask_r1", d, 8'h0F);
    write_reg(4'd0, 8'hFF);  read_reg(4'd0, d);  check("mask_r0", d, 8'hFF);
    write_reg(4'd6, 8'hFF);  read_reg(4'd6, d);  check("mask_r6", d, 8'h1F);
    write_reg(4'd8, 8'hFF);  read_reg(4'd8, d);  check("mask_r8", d, 8'h1F);
    write_reg(4'd13, 8'hFF); read_reg(4'd13, d); check("mask_r13", d, 8'h0F);
    write_reg(4'd14, 8'hFF); read_reg(4'd14, d); check("mask_r14", d, 8'hFF);

    // One shared bus: 0xA5 latches address 5 and writes 0x05 into the old address 3.
    write_reg(4'd5, 8'h07);
    addr_we = 1'b1; bus_data = 8'h03;
    cyc();
    data_we = 1'b1; bus_data = 8'hA5;
    cyc();
    addr_we = 1'b0; data_we = 1'b0; bus_data = 8'h00;
    cyc();
    check("samecycle_new_addr_r5", rd_data, 8'h07);
    read_reg(4'd3, d); check("samecycle_old_addr_r3", d, 8'h05);

    // Tone A with P=3: three ticks of two clocks per half-period.
    do_reset();
    write_reg(4'd0, 8'h03);
    write_reg(4'd7, 8'h3E);
    write_reg(4'd8, 8'h0F);
    wait_toggle(50, n);
    for (int k = 0; k < 4; k++) begin
      wait_toggle(20, n);
      check("tone_p3_half_period", n, 6);
    end
    bad = 0; hi = 0;
    for (int i = 0; i < 60; i++) begin
      prev = chan_out[0];
      cyc();
      if (audio_out !== (prev ? 8'd60 : 8'd0)) bad++;
      if (audio_out === 8'd60) hi++;
    end
    check("tone_audio_bad", bad, 0);
    check("tone_audio_high_seen", hi > 0, 1);

    // Period shrink below the running count wraps on the following tick.
    write_reg(4'd0, 8'hFF);
    wait_toggle(1200, n);
    wait_toggle(1200, n);
    check("tone_p255_half_period", n, 510);
    for (int i = 0; i < 400; i++) cyc();
    write_reg(4'd0, 8'd10);
    wait_toggle(8, n);
    check("shrink_toggle_soon", (n >= 1 && n <= 4), 1);
    wait_toggle(60, n);
    check("tone_p10_half_period", n, 20);
    write_reg(4'd0, 8'h00);
    wait_toggle(30, n);
    wait_toggle(30, n);
    wait_toggle(10, n); check("tone_p0_half_period_a", n, 2);
    wait_toggle(10, n); check("tone_p0_half_period_b", n, 2);

    reset = 1'b1;
    cyc();
    check("midreset_audio", audio_out, 8'h00);
    check("midreset_chan_out", chan_out, 3'b000);
    check("midreset_rd_data", rd_data, 8'h00);
    reset = 1'b0;
    read_reg(4'd0, d); check("midreset_r0", d, 8'h00);
    read_reg(4'd7, d); check("midreset_r7", d, 8'h3F);
    read_reg(4'd8, d); check("midreset_r8", d, 8'h00);

    // Noise on channel A only; the observed bit stream must appear in the reference LFSR stream.
    do_reset();
    write_reg(4'd6, 8'h01);
    write_reg(4'd7, 8'h37);
    write_reg(4'd8, 8'h08);
    cyc(); cyc();
    check("noise_other_chans_on", chan_out[2:1], 2'b11);
    for (int j = 0; j < 80; j++) begin
      obs[j] = chan_out[0];
      cyc(); cyc();
    end
    m = 17'h00001;
    for (int k = 0; k < 400; k++) begin
      mseq[k] = m[0];
      m = {m[0] ^ m[3], m[16:1]};
    end
    found = 1'b0;
    for (int o = 0; o < 300; o++) begin
      bit ok;
      ok = 1'b1;
      for (int j = 0; j < 80; j++) if (obs[j] != mseq[o+j]) ok = 1'b0;
      if (ok) found = 1'b1;
    end
    check("noise_matches_lfsr", found, 1'b1);

`ifdef AY_PSG_ENVELOPE_EN
    do_reset();
    write_reg(4'd11, 8'h01);
    write_reg(4'd13, 8'h0C);
    write_reg(4'd8, 8'h10);
    write_reg(4'd7, 8'h3F);
    cyc(); cyc();
    bad = 0; hi = 0;
    prev = 1'b0;
    d = audio_out;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (audio_out !== d) begin
        if (audio_out !== ((d + 8'd4) & 8'h3F)) bad++;
        if (audio_out === 8'd0) hi++;
        d = audio_out;
      end
    end
    check("env_saw_step_bad", bad, 0);
    check("env_saw_wraps", hi >= 2, 1);
    n = 0;
    while (audio_out !== 8'd28 && n < 100) begin cyc(); n++; end
    check("env_reach_level7", audio_out, 8'd28);
    write_reg(4'd13, 8'h0C);
    cyc();
    check("env_restart_level0", audio_out, 8'd0);
`else
    do_reset();
    write_reg(4'd8, 8'h10);
    write_reg(4'd7, 8'h3F);
    cyc(); cyc();
    check("noenv_bit4_ignored", audio_out, 8'd0);
    write_reg(4'd8, 8'h1A);
    cyc(); cyc();
    check("noenv_fixed_amp", audio_out, 8'd40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
